// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a 4-entry write FIFO and a per-frame baud divisor.
// The divisor is latched from the baudrate input each time a byte is popped from the FIFO.
module uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 48_000_000
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [31:0] baudrate,
  input  logic        i_Tx_DV,
  input  logic [7:0]  i_Tx_Byte,
  output logic        o_Tx_Ready,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done,
  output logic [2:0]  o_Fifo_Count,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0] CLK_HZ = 32'(CLK_FREQ_HZ);

  state_t      state, state_nxt;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic [7:0]  shreg, shreg_nxt;
  logic [15:0] div_q, div_nxt, div_calc;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        serial_nxt;
  logic        wr_en, pop, bit_end;
  logic [31:0] quot;

  // Handshake: a byte transfers on any rising edge where i_Tx_DV and o_Tx_Ready
  // are both high; o_Tx_Ready depends only on occupancy, never on this cycle's pop.
  assign o_Tx_Ready   = (count < 3'd4);
  assign wr_en        = i_Tx_DV && o_Tx_Ready;
  assign pop          = (state == IDLE) && (count != 3'd0);
  assign o_Fifo_Count = count;

  // Divisor for the next frame; the zero guard keeps the divide defined.
  always_comb begin
    quot = CLK_HZ / ((baudrate == 32'd0) ? 32'd1 : baudrate);
    if ((baudrate == 32'd0) || (quot < 32'd2)) begin
      div_calc = 16'd2;
    end else if (quot > 32'd65535) begin
      div_calc = 16'hFFFF;
    end else begin
      div_calc = quot[15:0];
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 2'd1;
      if (pop)   rd_ptr <= rd_ptr + 2'd1;
      case ({wr_en, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) fifo_mem[wr_ptr] <= i_Tx_Byte;
  end

  assign bit_end = (cnt == (div_q - 16'd1));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shreg_nxt  = shreg;
    div_nxt    = div_q;
    serial_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt = START;
          shreg_nxt = fifo_mem[rd_ptr];
          div_nxt   = div_calc;
          cnt_nxt   = 16'd0;
          idx_nxt   = 3'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          cnt_nxt   = 16'd0;
          idx_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = 16'd0;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = DONE;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Line level is registered from the next state so it tracks the state register exactly.
    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shreg_nxt[idx_nxt];
      default: serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      idx         <= 3'd0;
      shreg       <= 8'd0;
      div_q       <= 16'd2;
      o_Tx_Serial <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shreg       <= shreg_nxt;
      div_q       <= div_nxt;
      o_Tx_Serial <= serial_nxt;
    end
  end

  assign o_Tx_Active = (state == START) || (state == DATA) || (state == STOP);
  assign o_Tx_Done   = (state == DONE);
  assign fsm_state   = state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a queue-based line-waveform model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx;

  localparam int unsigned CLK_HZ = 48_000_000;

  logic        i_Clock   = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic [31:0] baudrate  = 32'd12_000_000;
  logic        i_Tx_DV   = 1'b0;
  logic [7:0]  i_Tx_Byte = 8'd0;
  logic        o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
  logic [2:0]  o_Fifo_Count, fsm_state;

  int errors = 0;
  int checks = 0;

  uart_tx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .baudrate     (baudrate),
    .i_Tx_DV      (i_Tx_DV),
    .i_Tx_Byte    (i_Tx_Byte),
    .o_Tx_Ready   (o_Tx_Ready),
    .o_Tx_Serial  (o_Tx_Serial),
    .o_Tx_Active  (o_Tx_Active),
    .o_Tx_Done    (o_Tx_Done),
    .o_Fifo_Count (o_Fifo_Count),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int n_of(input logic [31:0] b);
    longint q;
    if (b == 32'd0) return 2;
    q = longint'(CLK_HZ) / longint'(b);
    if (q < 2) return 2;
    if (q > 65535) return 65535;
    return int'(q);
  endfunction

  logic [7:0] m_q[$];      // bytes accepted but not yet started
  logic [2:0] wave_q[$];   // upcoming {serial, active, done} per clock
  logic [2:0] cur;
  bit         cur_idle;
  bit         s_dv;
  logic [7:0] s_byte, b;
  logic [31:0] s_baud;
  int         pre, n;

  always @(posedge i_Clock) begin
    s_dv   = i_Tx_DV;
    s_byte = i_Tx_Byte;
    s_baud = baudrate;
    if (!i_Reset_n) begin
      m_q.delete();
      wave_q.delete();
      cur      = 3'b100;
      cur_idle = 1'b1;
    end else begin
      pre = m_q.size();
      if (cur_idle && pre > 0) begin
        b = m_q.pop_front();
        n = n_of(s_baud);
        for (int i = 0; i < n; i++) wave_q.push_back(3'b010);
        for (int j = 0; j < 8; j++)
          for (int i = 0; i < n; i++) wave_q.push_back({b[j], 2'b10});
        for (int i = 0; i < n; i++) wave_q.push_back(3'b110);
        wave_q.push_back(3'b101);
      end
      if (s_dv && pre < 4) m_q.push_back(s_byte);
      if (wave_q.size() > 0) begin
        cur      = wave_q.pop_front();
        cur_idle = 1'b0;
      end else begin
        cur      = 3'b100;
        cur_idle = 1'b1;
      end
    end
    #1;
    check("serial", o_Tx_Serial, cur[2]);
    check("active", o_Tx_Active, cur[1]);
    check("done",   o_Tx_Done,   cur[0]);
    check("count",  o_Fifo_Count, m_q.size());
    check("ready",  o_Tx_Ready, (m_q.size() < 4) ? 1 : 0);
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic v, input logic [7:0] d);
    @(negedge i_Clock);
    i_Tx_DV   = v;
    i_Tx_Byte = d;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((o_Fifo_Count != 3'd0 || o_Tx_Active || o_Tx_Done) && t < 3000) begin
      @(negedge i_Clock);
      t++;
    end
    check("drain_timeout", (t < 3000) ? 1 : 0, 1);
    repeat (3) @(negedge i_Clock);
  endtask

  task automatic measure(output int len);
    int t = 0;
    len = 0;
    while (!o_Tx_Active && t < 500) begin
      @(negedge i_Clock);
      t++;
    end
    while (o_Tx_Active && len < 2000) begin
      @(negedge i_Clock);
      len++;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [9:0]  pat;
  logic [39:0] got_v, exp_v;
  int          done_cnt, act_cnt, len1, len2, prev, bad;
  bit          seen;
  logic [31:0] bauds [7];

  initial begin
    bauds = '{32'd12_000_000, 32'd8_000_000, 32'd16_000_000, 32'd24_000_000,
              32'd0, 32'd48_000_000, 32'd100_000_000};
    repeat (3) @(negedge i_Clock);
    #1;
    check("rst_serial", o_Tx_Serial, 1);
    check("rst_active", o_Tx_Active, 0);
    check("rst_done",   o_Tx_Done, 0);
    check("rst_count",  o_Fifo_Count, 0);
    check("rst_ready",  o_Tx_Ready, 1);
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    repeat (3) @(negedge i_Clock);

    // Single 0xA5 frame at N=4
    baudrate = 32'd12_000_000;
    put(1'b1, 8'hA5);
    put(1'b0, 8'h00);
    pat = 10'b1101001010;
    done_cnt = 0;
    act_cnt  = 0;
    for (int i = 0; i < 44; i++) begin
      @(negedge i_Clock);
      if (i < 40) got_v[i] = o_Tx_Serial;
      done_cnt += int'(o_Tx_Done);
      act_cnt  += int'(o_Tx_Active);
    end
    for (int i = 0; i < 40; i++) exp_v[i] = pat[i / 4];
    check("a5_waveform", got_v, exp_v);
    check("a5_done_pulses", done_cnt, 1);
    check("a5_active_clocks", act_cnt, 40);
    wait_idle();

    // Burst of six writes: fifth fits, sixth dropped while full
    for (int i = 1; i <= 6; i++) put(1'b1, 8'(i));
    put(1'b0, 8'h00);
    check("peak_count", o_Fifo_Count, 4);
    check("full_not_ready", o_Tx_Ready, 0);
    repeat (20) @(negedge i_Clock);
    // Hold a write while full across the next pop: it must be dropped, count 4 -> 3
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = 8'h77;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev = int'(o_Fifo_Count);
      @(negedge i_Clock);
      if (!seen && prev == 4 && o_Fifo_Count != 3'd4) begin
        check("drop_on_pop", o_Fifo_Count, 3);
        seen = 1'b1;
      end
    end
    check("drop_on_pop_seen", seen, 1);
    i_Tx_DV = 1'b0;
    wait_idle();

    // Divisor clamps
    baudrate = 32'd0;
    put(1'b1, 8'h5A);
    put(1'b0, 8'h00);
    measure(len1);
    check("baud0_frame", len1, 20);
    wait_idle();
    baudrate = 32'd48_000_000;
    put(1'b1, 8'hC3);
    put(1'b0, 8'h00);
    measure(len1);
    check("baud48m_frame", len1, 20);
    wait_idle();

    // Baud change mid-frame only affects the following frame
    baudrate = 32'd12_000_000;
    put(1'b1, 8'h3C);
    put(1'b1, 8'h96);
    put(1'b0, 8'h00);
    fork
      measure(len1);
      begin
        repeat (15) @(negedge i_Clock);
        baudrate = 32'd6_000_000;
      end
    join
    measure(len2);
    check("old_baud_frame", len1, 40);
    check("new_baud_frame", len2, 80);
    wait_idle();

    // Reset during bit 3 with two bytes queued
    baudrate = 32'd12_000_000;
    put(1'b1, 8'h11);
    put(1'b1, 8'h22);
    put(1'b1, 8'h33);
    put(1'b0, 8'h00);
    repeat (16) @(negedge i_Clock);
    check("bit3_low", o_Tx_Serial, 0);
    check("queued_two", o_Fifo_Count, 2);
    i_Reset_n = 1'b0;
    #1;
    check("abort_serial", o_Tx_Serial, 1);
    check("abort_count",  o_Fifo_Count, 0);
    check("abort_active", o_Tx_Active, 0);
    check("abort_done",   o_Tx_Done, 0);
    repeat (3) @(negedge i_Clock);
    i_Reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_Clock);
      if (o_Tx_Active || o_Tx_Done || !o_Tx_Serial) bad++;
    end
    check("quiet_after_reset", bad, 0);

    // Randomized traffic with occasional baud changes
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) baudrate = bauds[$urandom_range(0, 6)];
      put(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)));
    end
    put(1'b0, 8'h00);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 48_000_000, meaning i_Clock frequency in Hz.
REQ-002 SHALL have port i_Clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port baudrate  input  32  line rate in baud; sampled only at frame start.
REQ-005 SHALL have port i_Tx_DV  input  1  write strobe for i_Tx_Byte.
REQ-006 SHALL have port i_Tx_Byte  input  8  byte to transmit.
REQ-007 SHALL have port o_Tx_Ready  output  1  high while the FIFO can accept a write.
REQ-008 SHALL have port o_Tx_Serial  output  1  serial line, idle high, registered.
REQ-009 SHALL have port o_Tx_Active  output  1  high during start, data and stop bits.
REQ-010 SHALL have port o_Tx_Done  output  1  one-cycle pulse after each stop bit completes.
REQ-011 SHALL have port o_Fifo_Count  output  3  FIFO occupancy, 0..4.

Function
REQ-012 SHALL implement 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-013 SHALL buffer bytes in a 4-entry FIFO; o_Tx_Ready = (o_Fifo_Count < 4), combinational.
REQ-014 SHALL write i_Tx_Byte into the FIFO on an edge where i_Tx_DV=1 and o_Tx_Ready=1; a write while full SHALL be dropped with count unchanged, even if a pop occurs in the same cycle.
REQ-015 SHALL update count by +1 on write only, -1 on pop only, and leave it unchanged on simultaneous write and pop.
REQ-016 SHALL use states IDLE, START, DATA, STOP, DONE.
REQ-017 IDLE: o_Tx_Serial=1; if FIFO non-empty, pop the head byte into a shift register, latch divisor N, go START; else stay.
REQ-018 SHALL compute N = CLK_FREQ_HZ/baudrate (integer division), clamped to 2 when baudrate=0 or the quotient is <2, held in a 16-bit register; the quotient SHALL saturate to 65535 when larger.
REQ-019 START: o_Tx_Serial=0 for exactly N clocks, then DATA with bit index 0.
REQ-020 DATA: drive bit[index] for exactly N clocks each; after bit 7 go STOP; the bit index SHALL be 3 bits wide and SHALL not wrap mid-frame.
REQ-021 STOP: o_Tx_Serial=1 for exactly N clocks, then DONE.
REQ-022 DONE: o_Tx_Done=1 for one cycle, o_Tx_Serial=1, then IDLE.
REQ-023 A write accepted at edge k into an empty FIFO while in IDLE SHALL cause o_Tx_Serial to go low after edge k+1; a full frame SHALL last 10*N clocks.
REQ-024 Back-to-back frames SHALL have exactly 2 extra high cycles (DONE, IDLE) between stop bit end and the next start bit.
REQ-025 A baudrate change mid-frame SHALL not affect the current frame; it takes effect at the next IDLE pop.
REQ-026 o_Tx_Active SHALL be 1 exactly in START, DATA and STOP.
REQ-027 Bytes SHALL be transmitted in write order, with none lost or duplicated.

Reset
REQ-028 While i_Reset_n=0, asynchronously: state IDLE, FIFO emptied (count 0), o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, counters 0, o_Tx_Ready=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with the line high; no o_Tx_Done pulse.
REQ-030 Operation SHALL resume on the first rising edge after i_Reset_n deasserts.

Verification
REQ-031 CLK_FREQ_HZ=48e6, baudrate=12e6 (N=4), write 0xA5 -> serial 0,1,0,1,0,0,1,0,1,1 at 4 clocks each, 40 clocks; o_Tx_Done pulses once.
REQ-032 Same setup, write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles from idle -> 5th write accepted (the 1st has already popped), count peaks at 4; writing a 6th byte while count=4 is dropped; output is 01..05 with 2 high cycles between frames.
REQ-033 baudrate=0 -> N=2, frame of 20 clocks; baudrate=48e6 -> N=2 as well.
REQ-034 baudrate changes 12e6->6e6 during the DATA bits of 0x3C -> current frame stays at N=4; the next frame uses N=8.
REQ-035 Assert i_Reset_n=0 during bit 3 of a frame with 2 bytes queued -> o_Tx_Serial=1 immediately, count=0, no o_Tx_Done, and no output after release.
REQ-036 Write while full with a simultaneous pop (DONE->IDLE) -> the write is dropped and count decrements by 1.
